// File: rtl/matmul_mac_engine.sv
// Self-sequenced DIM x DIM unsigned matrix multiplier: host loads A/B, an internal FSM
// walks fetch/multiply-accumulate/store per element, results are read back in OUT_W lanes.
module matmul_mac_engine #(
  parameter int DATA_W = 8,
  parameter int DIM    = 3,
  parameter int ACC_W  = 18,
  parameter int OUT_W  = 8,
  localparam int NEL   = DIM * DIM,
  localparam int AW    = (NEL > 1) ? $clog2(NEL) : 1,
  localparam int NPART = (ACC_W + OUT_W - 1) / OUT_W,
  localparam int PW    = (NPART > 1) ? $clog2(NPART) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic              load_sel,
  input  logic [AW-1:0]     load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [AW-1:0]     rd_addr,
  input  logic [PW-1:0]     rd_part,
  output logic [OUT_W-1:0]  rd_data
);

  localparam int CW   = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int PADW = NPART * OUT_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_MAC   = 3'd2;
  localparam logic [2:0] S_STORE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [CW-1:0]       i_q, i_d, j_q, j_d, k_q, k_d;
  logic [DATA_W-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [DATA_W-1:0]   a_q [NEL];
  logic [DATA_W-1:0]   a_d [NEL];
  logic [DATA_W-1:0]   b_q [NEL];
  logic [DATA_W-1:0]   b_d [NEL];
  logic [ACC_W-1:0]    c_q [NEL];
  logic [ACC_W-1:0]    c_d [NEL];
  logic                busy_q, busy_d, done_q, done_d;
  logic [OUT_W-1:0]    rd_data_q, rd_data_d;

  logic                load_ready_s;
  logic                last_i_s, last_j_s, last_k_s;
  logic [AW-1:0]       idx_a_s, idx_b_s, idx_c_s;
  logic [2*DATA_W-1:0] prod_s;
  logic [PADW-1:0]     c_pad_s;

  assign load_ready_s = (state_q == S_IDLE) || (state_q == S_DONE);
  assign last_i_s     = (i_q == CW'(DIM - 1));
  assign last_j_s     = (j_q == CW'(DIM - 1));
  assign last_k_s     = (k_q == CW'(DIM - 1));
  assign idx_a_s      = AW'(32'(i_q) * DIM + 32'(k_q));
  assign idx_b_s      = AW'(32'(k_q) * DIM + 32'(j_q));
  assign idx_c_s      = AW'(32'(i_q) * DIM + 32'(j_q));
  assign prod_s       = {{DATA_W{1'b0}}, opa_q} * {{DATA_W{1'b0}}, opb_q};

  // Sequencer, operand/accumulator datapath and the A/B/C stores.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;

    if (load_valid && load_ready_s && (32'(load_addr) < NEL)) begin
      if (load_sel) begin
        b_d[load_addr] = load_data;
      end else begin
        a_d[load_addr] = load_data;
      end
    end else begin
      a_d = a_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        opa_d   = a_q[idx_a_s];
        opb_d   = b_q[idx_b_s];
        state_d = S_MAC;
        if (k_q == '0) begin
          acc_d = '0;
        end else begin
          acc_d = acc_q;
        end
      end
      S_MAC: begin
        // Accumulator wraps modulo 2^ACC_W by construction.
        acc_d = acc_q + ACC_W'(prod_s);
        if (last_k_s) begin
          state_d = S_STORE;
        end else begin
          k_d     = k_q + CW'(1);
          state_d = S_FETCH;
        end
      end
      S_STORE: begin
        c_d[idx_c_s] = acc_q;
        k_d          = '0;
        if (!last_j_s) begin
          j_d     = j_q + CW'(1);
          state_d = S_FETCH;
        end else if (!last_i_s) begin
          j_d     = '0;
          i_d     = i_q + CW'(1);
          state_d = S_FETCH;
        end else begin
          j_d     = '0;
          i_d     = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_FETCH) || (state_d == S_MAC) || (state_d == S_STORE);
    done_d = (state_d == S_DONE);
  end

  // Readout lane select with zero padding above ACC_W.
  always_comb begin
    c_pad_s   = '0;
    rd_data_d = '0;
    if ((32'(rd_addr) < NEL) && (32'(rd_part) < NPART)) begin
      c_pad_s   = PADW'(c_q[rd_addr]);
      rd_data_d = c_pad_s[32'(rd_part) * OUT_W +: OUT_W];
    end else begin
      rd_data_d = '0;
    end
  end

  // State, datapath, store and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
      for (int n = 0; n < NEL; n++) begin
        a_q[n] <= '0;
        b_q[n] <= '0;
        c_q[n] <= '0;
      end
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
    end
  end

  assign load_ready = load_ready_s;
  assign busy       = busy_q;
  assign done       = done_q;
  assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_matmul_mac_engine.sv
// Randomised bench for matmul_mac_engine: a plain-arithmetic matrix model feeds a read
// scoreboard that a separate monitor drains; run timing and control are checked inline.
module tb_matmul_mac_engine;

  localparam int NEL   = 9;
  localparam int NPART = 3;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic       load_ready;
  logic       load_sel;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic       start;
  logic       busy;
  logic       done;
  logic [3:0] rd_addr;
  logic [1:0] rd_part;
  logic [7:0] rd_data;

  matmul_mac_engine dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready), .load_sel(load_sel),
    .load_addr(load_addr), .load_data(load_data),
    .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_part(rd_part), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ma [NEL];
  int mb [NEL];
  int mc [NEL];

  typedef struct { int addr; int part; int exp; } rd_t;
  rd_t sbq [$];
  logic rd_issue = 1'b0;
  logic rd_chk   = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: C = A x B in plain integer arithmetic, truncated to 18 bits.
  function automatic void model_run();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        int s = 0;
        for (int k = 0; k < 3; k++) s += ma[i*3+k] * mb[k*3+j];
        mc[i*3+j] = s & 32'h3FFFF;
      end
  endfunction

  function automatic int lane(input int addr, input int part);
    if (addr >= NEL || part >= NPART) return 0;
    return (mc[addr] >> (8 * part)) & 255;
  endfunction

  function automatic void model_clear();
    for (int e = 0; e < NEL; e++) begin ma[e] = 0; mb[e] = 0; mc[e] = 0; end
  endfunction

  always @(posedge clk) rd_chk <= rd_issue;

  // Scoreboard monitor: one expected entry per registered read.
  always @(negedge clk) begin : monitor
    rd_t e;
    if (rd_chk) begin
      if (sbq.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = sbq.pop_front();
        check($sformatf("rd C[%0d].lane%0d", e.addr, e.part), rd_data, e.exp);
      end
    end
  end

  task automatic load(input bit sel, input int addr, input int data);
    load_valid = 1'b1; load_sel = sel; load_addr = addr[3:0]; load_data = data[7:0];
    #1 check("load_ready_idle", load_ready, 1);
    @(negedge clk);
    load_valid = 1'b0;
    if (addr < NEL) begin
      if (sel) mb[addr] = data; else ma[addr] = data;
    end
  endtask

  task automatic rd(input int addr, input int part);
    rd_addr = addr[3:0]; rd_part = part[1:0]; rd_issue = 1'b1;
    sbq.push_back('{addr, part, lane(addr, part)});
    @(negedge clk);
    rd_issue = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < NEL; a++)
      for (int p = 0; p < 4; p++) rd(a, p);
    rd(9, 0);
    rd(15, 1);
    repeat (2) @(negedge clk);
    check("sb_drained", sbq.size(), 0);
  endtask

  task automatic load_random();
    for (int e = 0; e < NEL; e++) load(1'b0, e, $urandom_range(0, 255));
    for (int e = 0; e < NEL; e++) load(1'b1, e, $urandom_range(0, 255));
  endtask

  // One run from IDLE; optional busy-time load/start pokes, same-cycle load, or mid-run reset.
  task automatic run(input int ld_at, input int st_at, input int rst_at, input bit sim_ld);
    int n; int busy_cnt; bit got; int sa; int sd; bit ss;
    busy_cnt = 0; got = 1'b0;
    if (sim_ld) begin
      ss = 1'($urandom_range(0, 1)); sa = $urandom_range(0, 8); sd = $urandom_range(0, 255);
      load_valid = 1'b1; load_sel = ss; load_addr = sa[3:0]; load_data = sd[7:0];
      if (ss) mb[sa] = sd; else ma[sa] = sd;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; load_valid = 1'b0;
    n = 1;
    while (n < 200) begin
      if (n == rst_at) begin
        rst = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_load_ready", load_ready, 1);
        check("rst_mid_rd_data", rd_data, 0);
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        return;
      end
      if (done) begin got = 1'b1; break; end
      if (busy) busy_cnt++;
      if (n == ld_at) begin
        load_valid = 1'b1; load_sel = 1'($urandom_range(0, 1));
        load_addr = 4'($urandom_range(0, 8)); load_data = 8'($urandom_range(0, 255));
        #1 check("load_ready_busy", load_ready, 0);
      end
      if (n == ld_at + 1) load_valid = 1'b0;
      if (n == st_at) start = 1'b1;
      if (n == st_at + 1) start = 1'b0;
      @(negedge clk);
      n++;
    end
    check("done_latency", got ? n : -1, 64);
    check("busy_cycles", busy_cnt, 63);
    check("busy_at_done", busy, 0);
    model_run();
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    int n; int d1; int d2; int lowcnt;
    rst = 1'b0; load_valid = 1'b0; load_sel = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; rd_addr = '0; rd_part = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_rd_data", rd_data, 0);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_load_ready", load_ready, 1);
    read_all();

    // Identity A, B = 1..9: C equals B.
    for (int e = 0; e < NEL; e++) load(1'b0, e, (e % 4 == 0) ? 1 : 0);
    for (int e = 0; e < NEL; e++) load(1'b1, e, e + 1);
    run(-1, -1, -1, 1'b0);
    read_all();

    // All-255 operands: largest unwrapped result.
    for (int e = 0; e < NEL; e++) begin load(1'b0, e, 255); load(1'b1, e, 255); end
    run(-1, -1, -1, 1'b0);
    check("model_full_scale", mc[4], 195075);
    read_all();

    // Loads and start pokes while busy are ignored.
    load_random();
    run(10, 20, -1, 1'b0);
    read_all();

    // start held high across two runs.
    start = 1'b1; n = 0; d1 = -1; d2 = -1; lowcnt = 0;
    while (n < 300 && d2 < 0) begin
      @(negedge clk);
      n++;
      if (done) begin
        check("busy_in_done", busy, 0);
        if (d1 < 0) d1 = n; else begin d2 = n; start = 1'b0; end
      end else if (d1 >= 0 && !busy) begin
        lowcnt++;
      end
    end
    check("held_first_done", d1, 64);
    check("held_period", d2 - d1, 65);
    check("held_idle_cycles", lowcnt, 1);
    repeat (2) @(negedge clk);
    check("held_stopped", busy, 0);
    model_run();
    read_all();

    // Out-of-range loads are dropped.
    load(1'b0, 9, 8'hAA);
    load(1'b1, 9, 8'h55);
    run(-1, -1, -1, 1'b0);
    read_all();

    // Random operands with a load in the start cycle.
    for (int r = 0; r < 3; r++) begin
      load_random();
      run(-1, -1, -1, 1'b1);
      read_all();
    end

    // Reset at cycle 20 of a run clears everything.
    run(-1, -1, 20, 1'b0);
    @(negedge clk);
    read_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
